fp_result_queue: RTL
====================

FP_RESULT_QUEUE -- requirements
Module: fp_result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of result entries held; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the product/overflow pair from FP_multiplier is valid this cycle.
REQ-005 SHALL have port product, input, 32 bits: IEEE-754 single-precision product from FP_multiplier.
REQ-006 SHALL have port overflow, input, 1 bit: multiplier overflow flag accompanying product.
REQ-007 SHALL have port rd_en, input, 1 bit: consumer pops the head entry this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: the queue is non-empty and the head is presented.
REQ-009 SHALL have port out_data, output, 32 bits: head entry value.
REQ-010 SHALL have port out_ovf, output, 1 bit: overflow flag stored with the head entry.
REQ-011 SHALL have port out_class, output, 3 bits: class of the head entry.
REQ-012 SHALL have port full, output, 1 bit: the queue holds DEPTH entries.
REQ-013 SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-014 SHALL have port drop_err, output, 1 bit: sticky flag, a write was lost to full.
REQ-015 SHALL have port ovf_count, output, 8 bits: saturating count of accepted entries with overflow=1.

Function
REQ-016 SHALL accept an entry on a rising edge when in_valid=1 and (full=0 or rd_en=1).
REQ-017 SHALL store a fixed value instead of product when overflow=1 on an accepted write: signed infinity {product[31], 8'hFF, 23'h0}. Otherwise it SHALL store product unchanged.
REQ-018 SHALL compute the class at write time from the stored value:
- 000: exp=0 and frac=0 (zero)
- 001: exp 1..254 (normal)
- 010: exp=0 and frac!=0 (subnormal)
- 011: exp=255 and frac=0 (infinity)
- 100: exp=255 and frac!=0 (NaN)
REQ-019 SHALL be first-word-fall-through: out_data, out_ovf and out_class reflect the head combinationally from storage whenever out_valid=1.
REQ-020 SHALL hold out_data, out_ovf and out_class at their last value when out_valid=0; they are don't-care to the consumer.
REQ-021 SHALL pop the head on a rising edge when rd_en=1 and out_valid=1; rd_en when empty SHALL be ignored with no pointer or count change.
REQ-022 SHALL give write-to-out_valid latency of one cycle: an entry written at edge N is visible after edge N.
REQ-023 SHALL, on simultaneous write and read when non-empty (including full), perform both and leave count unchanged.
REQ-024 SHALL, on simultaneous write and read when empty, accept the write, ignore the read, and set count to 1.
REQ-025 SHALL, on in_valid=1 with full=1 and rd_en=0, discard the write, leave pointers unchanged, and set drop_err=1 until reset.
REQ-026 SHALL use read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-027 SHALL drive full=(count==DEPTH) and out_valid=(count!=0).
REQ-028 SHALL increment ovf_count by one per accepted write with overflow=1, saturating at 255; dropped writes SHALL NOT count.

Reset
REQ-029 SHALL, while reset=1, asynchronously force:
- pointers=0, count=0, out_valid=0, full=0
- drop_err=0, ovf_count=0
- out_data=0, out_ovf=0, out_class=000
REQ-030 SHALL, on reset asserted mid-operation, discard all stored entries; the first edge after deassertion with in_valid=1 SHALL be accepted normally.

Verification
REQ-031 Single result: product=32'hC32B0000 (-18 x 9.5), overflow=0, one in_valid pulse -> next cycle out_valid=1, out_data=C32B0000, out_class=001, out_ovf=0, count=1; rd_en pulse -> out_valid=0, count=0.
REQ-032 Overflow substitution: product=32'h8000_1234, overflow=1 -> out_data=FF800000, out_class=011, out_ovf=1, ovf_count=1.
REQ-033 Classes: write 00000000, 00000001, 7FC00000, 3F800000 -> pops give classes 000, 010, 100, 001 in order.
REQ-034 Full/drop: 5 writes with DEPTH=4, no reads -> full=1, count=4, drop_err=1; pops return writes 1-4 only.
REQ-035 Simultaneous events:
- full, in_valid=1 and rd_en=1 -> count stays 4, drop_err stays 0, and the new entry appears after 3 more pops.
- empty, in_valid=1 and rd_en=1 -> count=1.
REQ-036 Reset mid-stream: 3 entries queued, reset pulsed asynchronously between edges -> count=0, out_valid=0, ovf_count=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/fp_result_queue.sv
// fp_result_queue: first-word-fall-through queue of FP multiplier results.
// Overflowed products become signed infinity; each entry is classed when written.
module fp_result_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [31:0]             product,
    input  logic                    overflow,
    input  logic                    rd_en,
    output logic                    out_valid,
    output logic [31:0]             out_data,
    output logic                    out_ovf,
    output logic [2:0]              out_class,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop_err,
    output logic [7:0]              ovf_count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   data_mem [DEPTH];
    logic          ovf_mem  [DEPTH];
    logic [2:0]    cls_mem  [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          drop_q, drop_d;
    logic [7:0]    ovfc_q, ovfc_d;
    logic [31:0]   last_data_q;
    logic          last_ovf_q;
    logic [2:0]    last_cls_q;
    logic          wr, rd;
    logic [31:0]   wdata;
    logic [7:0]    wexp;
    logic [22:0]   wfrac;
    logic [2:0]    wcls;

    assign full      = count_q == (AW+1)'(DEPTH);
    assign out_valid = count_q != '0;
    assign count     = count_q;
    assign drop_err  = drop_q;
    assign ovf_count = ovfc_q;
    // Outputs keep the last popped head once empty; reset zeroes that copy.
    assign out_data  = out_valid ? data_mem[rptr_q] : last_data_q;
    assign out_ovf   = out_valid ? ovf_mem[rptr_q]  : last_ovf_q;
    assign out_class = out_valid ? cls_mem[rptr_q]  : last_cls_q;

    always_comb begin
        wdata   = overflow ? {product[31], 8'hFF, 23'h0} : product;
        wexp    = wdata[30:23];
        wfrac   = wdata[22:0];
        wcls    = (wexp == 8'h00) ? ((wfrac == '0) ? 3'b000 : 3'b010) :
                  (wexp == 8'hFF) ? ((wfrac == '0) ? 3'b011 : 3'b100) : 3'b001;
        rd      = rd_en && out_valid;
        wr      = in_valid && (!full || rd_en);
        wptr_d  = wr ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = rd ? rptr_q + AW'(1) : rptr_q;
        count_d = (wr && !rd) ? count_q + (AW+1)'(1) :
                  (rd && !wr) ? count_q - (AW+1)'(1) : count_q;
        drop_d  = drop_q || (in_valid && full && !rd_en);
        ovfc_d  = (wr && overflow && ovfc_q != 8'hFF) ? ovfc_q + 8'd1 : ovfc_q;
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            data_mem[wptr_q] <= wdata;
            ovf_mem[wptr_q]  <= overflow;
            cls_mem[wptr_q]  <= wcls;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            drop_q      <= 1'b0;
            ovfc_q      <= '0;
            last_data_q <= '0;
            last_ovf_q  <= 1'b0;
            last_cls_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            ovfc_q      <= ovfc_d;
            last_data_q <= out_data;
            last_ovf_q  <= out_ovf;
            last_cls_q  <= out_class;
        end
    end
endmodule
